// File: rtl/dcache_controller.sv
// dcache_controller
// Sequences a 2-way set-associative, write-back / write-allocate data cache SRAM
// between the MEM stage and a line-wide main-memory port. Hits complete with no
// extra latency; a miss stalls the CPU while an optional dirty-victim write-back
// and a line refill run over a req/ack memory handshake. Victim (LRU) selection
// lives in the SRAM; this block only drives index/tag/data/enable/write.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cpu_addr_i/data_i     load/store byte address and store data
//   cpu_MemRead_i/Write_i load / store request (both high = store)
//   cpu_data_o            load data (hit word, else 0)
//   cpu_stall_o           stall pipeline until the access hits in IDLE
//   mem_data_i, mem_ack_i refill line, 1-cycle transaction-done pulse
//   mem_enable_o/write_o  registered memory request, 1 = write-back
//   mem_addr_o/data_o     registered line address / write-back line
//   sram_index_o/tag_o    set index, {valid, dirty, tag} to write
//   sram_data_o           line to write
//   sram_enable_o/write_o SRAM access / write strobe
//   sram_tag_i/data_i     hit-way tag/line on hit, LRU victim on miss
//   sram_hit_i            lookup hit
module dcache_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned OFS_W  = 5,
  parameter int unsigned TAG_W  = 23
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_W-1:0]        cpu_addr_i,
  input  logic [31:0]              cpu_data_i,
  input  logic                     cpu_MemRead_i,
  input  logic                     cpu_MemWrite_i,
  output logic [31:0]              cpu_data_o,
  output logic                     cpu_stall_o,
  input  logic [(8<<OFS_W)-1:0]    mem_data_i,
  input  logic                     mem_ack_i,
  output logic                     mem_enable_o,
  output logic                     mem_write_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [(8<<OFS_W)-1:0]    mem_data_o,
  output logic [IDX_W-1:0]         sram_index_o,
  output logic [TAG_W+1:0]         sram_tag_o,
  output logic [(8<<OFS_W)-1:0]    sram_data_o,
  output logic                     sram_enable_o,
  output logic                     sram_write_o,
  input  logic [TAG_W+1:0]         sram_tag_i,
  input  logic [(8<<OFS_W)-1:0]    sram_data_i,
  input  logic                     sram_hit_i
);

  localparam int unsigned LINE_W = 8 << OFS_W;
  localparam int unsigned WSEL_W = OFS_W - 2;

  typedef enum logic [2:0] {
    StIdle,
    StMiss,
    StWriteback,
    StRefill,
    StRefillOk
  } state_e;

  state_e              state_q;
  logic                mem_enable_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_data_q;

  logic [TAG_W-1:0]    tag;
  logic [IDX_W-1:0]    index;
  logic [WSEL_W-1:0]   word;
  logic [WSEL_W+4:0]   bit_ofs;
  logic                req;
  logic                wr;
  logic                victim_dirty;
  logic [ADDR_W-1:0]   line_addr;
  logic [ADDR_W-1:0]   victim_addr;
  logic [LINE_W-1:0]   merged_line;
  logic                unused_byte_ofs;

  assign tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign index        = cpu_addr_i[OFS_W +: IDX_W];
  assign word         = cpu_addr_i[2 +: WSEL_W];
  assign bit_ofs      = {word, 5'b00000};
  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  // A simultaneous read+write request is handled as a store.
  assign wr           = cpu_MemWrite_i;
  assign victim_dirty = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
  assign line_addr    = {tag, index, {OFS_W{1'b0}}};
  assign victim_addr  = {sram_tag_i[TAG_W-1:0], index, {OFS_W{1'b0}}};
  assign unused_byte_ofs = ^cpu_addr_i[1:0];

  assign sram_index_o  = index;
  assign sram_enable_o = req;
  assign cpu_stall_o   = req & ~(sram_hit_i & (state_q == StIdle));
  assign cpu_data_o    = sram_hit_i ? sram_data_i[bit_ofs +: 32] : 32'h0;

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // SRAM write path: store hit merges one word and marks the line dirty; the
  // refill ack cycle installs the fresh line clean. A pending store then
  // completes as an ordinary write hit once the FSM is back in IDLE.
  always_comb begin
    merged_line = sram_data_i;
    merged_line[bit_ofs +: 32] = cpu_data_i;
    sram_write_o = 1'b0;
    sram_data_o  = sram_data_i;
    sram_tag_o   = {1'b1, 1'b0, tag};
    if ((state_q == StIdle) && wr && sram_hit_i) begin
      sram_write_o = 1'b1;
      sram_data_o  = merged_line;
      sram_tag_o   = {1'b1, 1'b1, tag};
    end else if ((state_q == StRefill) && mem_ack_i) begin
      sram_write_o = 1'b1;
      sram_data_o  = mem_data_i;
      sram_tag_o   = {1'b1, 1'b0, tag};
    end
  end

  // Miss sequencer with registered memory-port outputs; mem_ack_i only steers
  // next-state, so there is no combinational ack->mem_* path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req && !sram_hit_i) state_q <= StMiss;
        end
        StMiss: begin
          mem_enable_q <= 1'b1;
          if (victim_dirty) begin
            // Capture the victim now; the SRAM keeps presenting it only while
            // the set is untouched, and the memory side needs it held stable.
            mem_write_q <= 1'b1;
            mem_addr_q  <= victim_addr;
            mem_data_q  <= sram_data_i;
            state_q     <= StWriteback;
          end else begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= line_addr;
            state_q     <= StRefill;
          end
        end
        StWriteback: begin
          if (mem_ack_i) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= line_addr;
            state_q     <= StRefill;
          end
        end
        StRefill: begin
          if (mem_ack_i) begin
            mem_enable_q <= 1'b0;
            state_q      <= StRefillOk;
          end
        end
        StRefillOk: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  localparam int LAT = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [3:0]   sram_index_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;

  int total;
  int bad;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .sram_index_o   (sram_index_o),
    .sram_tag_o     (sram_tag_o),
    .sram_data_o    (sram_data_o),
    .sram_enable_o  (sram_enable_o),
    .sram_write_o   (sram_write_o),
    .sram_tag_i     (sram_tag_i),
    .sram_data_i    (sram_data_i),
    .sram_hit_i     (sram_hit_i)
  );

  // Reference: flat CPU-visible memory plus per-set residency list
  // (index 0 = least recently used) with dirty flags.
  logic [31:0] ref_mem  [2048];
  logic [31:0] main_mem [2048];
  int          res_tag   [16][2];
  bit          res_dirty [16][2];
  int          res_n     [16];
  logic [31:0] exp_rf_addr;
  logic [31:0] exp_wb_addr;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_mem[{a[12:5], 3'(w)}];
    return l;
  endfunction

  // kind: 0 hit, 1 clean miss, 2 dirty-victim miss
  task automatic ref_access(input logic [31:0] a, input logic wr, output int kind,
                            output logic [22:0] vt);
    int s;
    int t;
    int pos;
    bit d;
    s = int'(a[8:5]);
    t = int'(a[31:9]);
    pos = -1;
    vt = '0;
    for (int i = 0; i < res_n[s]; i++) if (res_tag[s][i] == t) pos = i;
    if (pos >= 0) begin
      kind = 0;
      d = res_dirty[s][pos] | wr;
      if (pos == 0 && res_n[s] == 2) begin
        res_tag[s][0]   = res_tag[s][1];
        res_dirty[s][0] = res_dirty[s][1];
      end
      res_n[s]--;
    end else begin
      d = wr;
      if (res_n[s] == 2) begin
        kind = res_dirty[s][0] ? 2 : 1;
        vt = 23'(res_tag[s][0]);
        res_tag[s][0]   = res_tag[s][1];
        res_dirty[s][0] = res_dirty[s][1];
        res_n[s] = 1;
      end else begin
        kind = 1;
      end
    end
    res_tag[s][res_n[s]]   = t;
    res_dirty[s][res_n[s]] = d;
    res_n[s]++;
  endtask

  // SRAM environment: 2 ways x 16 sets, LRU victim presented on miss.
  logic [24:0]  tag_arr [16][2];
  logic [255:0] dat_arr [16][2];
  logic         lru     [16];
  logic         sram_clr;
  logic         hit0, hit1, sel;

  always_comb begin
    hit0 = tag_arr[sram_index_o][0][24] && (tag_arr[sram_index_o][0][22:0] == cpu_addr_i[31:9]);
    hit1 = tag_arr[sram_index_o][1][24] && (tag_arr[sram_index_o][1][22:0] == cpu_addr_i[31:9]);
    sram_hit_i = hit0 || hit1;
    sel = hit0 ? 1'b0 : (hit1 ? 1'b1 : lru[sram_index_o]);
    sram_tag_i  = tag_arr[sram_index_o][sel];
    sram_data_i = dat_arr[sram_index_o][sel];
  end

  always @(posedge clk_i) begin
    if (sram_clr) begin
      for (int s = 0; s < 16; s++) begin
        for (int w = 0; w < 2; w++) begin
          tag_arr[s][w] <= '0;
          dat_arr[s][w] <= '0;
        end
        lru[s] <= 1'b0;
      end
    end else if (sram_enable_o) begin
      if (sram_write_o) begin
        tag_arr[sram_index_o][sel] <= sram_tag_o;
        dat_arr[sram_index_o][sel] <= sram_data_o;
        lru[sram_index_o] <= ~sel;
      end else if (sram_hit_i) begin
        lru[sram_index_o] <= ~sel;
      end
    end
  end

  // Memory environment: ack LAT cycles after a request is seen.
  logic auto_en, auto_ack, man_ack;
  int   cnt;
  assign mem_ack_i = auto_ack | man_ack;

  always @(posedge clk_i) begin
    if (rst_i) begin
      auto_ack   <= 1'b0;
      cnt        <= 0;
      mem_data_i <= '0;
    end else begin
      auto_ack <= 1'b0;
      if (auto_en && mem_enable_o && !auto_ack) begin
        if (cnt == LAT - 1) begin
          cnt      <= 0;
          auto_ack <= 1'b1;
          for (int w = 0; w < 8; w++) begin
            if (mem_write_o) main_mem[{mem_addr_o[12:5], 3'(w)}] = mem_data_o[w*32 +: 32];
            else mem_data_i[w*32 +: 32] <= main_mem[{mem_addr_o[12:5], 3'(w)}];
          end
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  // Check every completed memory transaction.
  always @(negedge clk_i) begin
    if (!rst_i && mem_enable_o && mem_ack_i) begin
      if (mem_write_o) begin
        chk("wb_addr", 256'(mem_addr_o), 256'(exp_wb_addr));
        chk("wb_data", mem_data_o, ref_line(exp_wb_addr));
        chk("wb_no_sram_we", 256'(sram_write_o), 256'(0));
      end else begin
        chk("rf_addr", 256'(mem_addr_o), 256'(exp_rf_addr));
        chk("rf_sram_we", 256'(sram_write_o), 256'(1));
        chk("rf_tag", 256'(sram_tag_o), 256'({2'b10, cpu_addr_i[31:9]}));
        chk("rf_data", sram_data_o, ref_line(exp_rf_addr));
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic wr, input logic [31:0] d);
    int kind;
    logic [22:0] vt;
    int stalls;
    int exp_st;
    logic [255:0] line;
    @(negedge clk_i);
    cpu_addr_i     = a;
    cpu_data_i     = d;
    cpu_MemWrite_i = wr;
    cpu_MemRead_i  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    ref_access(a, wr, kind, vt);
    exp_rf_addr = {a[31:5], 5'b0};
    exp_wb_addr = {vt, a[8:5], 5'b0};
    stalls = 0;
    #1;
    chk("sram_index", 256'(sram_index_o), 256'(a[8:5]));
    chk("sram_en", 256'(sram_enable_o), 256'(1));
    while (cpu_stall_o !== 1'b0 && stalls < 200) begin
      @(negedge clk_i);
      #1;
      stalls++;
    end
    exp_st = (kind == 0) ? 0 : ((kind == 1) ? LAT + 4 : 2 * LAT + 5);
    chk("stall_cycles", 256'(stalls), 256'(exp_st));
    chk("mem_idle", 256'(mem_enable_o), 256'(0));
    if (wr) begin
      line = ref_line(a);
      line[int'(a[4:2])*32 +: 32] = d;
      chk("st_we", 256'(sram_write_o), 256'(1));
      chk("st_tag", 256'(sram_tag_o), 256'({2'b11, a[31:9]}));
      chk("st_data", sram_data_o, line);
      ref_mem[a[12:2]] = d;
    end else begin
      chk("ld_data", 256'(cpu_data_o), 256'(ref_mem[a[12:2]]));
    end
  endtask

  initial begin
    int k;
    total = 0;
    bad = 0;
    rst_i = 1'b1;
    sram_clr = 1'b1;
    auto_en = 1'b1;
    man_ack = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    exp_rf_addr = '0;
    exp_wb_addr = '0;
    for (int i = 0; i < 2048; i++) begin
      main_mem[i] = $urandom;
      ref_mem[i]  = main_mem[i];
    end
    main_mem[256] = 32'hDEADBEEF;
    ref_mem[256]  = 32'hDEADBEEF;
    for (int s = 0; s < 16; s++) res_n[s] = 0;
    repeat (3) @(posedge clk_i);
    sram_clr = 1'b0;
    @(negedge clk_i);
    #1;
    chk("rst_en", 256'(mem_enable_o), 256'(0));
    chk("rst_wr", 256'(mem_write_o), 256'(0));
    chk("rst_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_data", mem_data_o, 256'(0));
    chk("rst_stall", 256'(cpu_stall_o), 256'(0));
    rst_i = 1'b0;

    // Directed: cold load, line hits, store hit, dirty eviction, store miss.
    do_op(32'h0000_0400, 1'b0, 32'h0);
    do_op(32'h0000_0404, 1'b0, 32'h0);
    do_op(32'h0000_0408, 1'b1, 32'h1234_5678);
    do_op(32'h0000_0800, 1'b0, 32'h0);
    do_op(32'h0000_0C00, 1'b0, 32'h0);
    do_op(32'h0000_1020, 1'b1, $urandom);
    do_op(32'h0000_1024, 1'b0, 32'h0);

    // Random mix over two sets with enough tags to force evictions.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 7)) << 9) | (32'($urandom_range(0, 1)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      do_op(a, 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset in the middle of a refill; a late ack must be ignored.
    auto_en = 1'b0;
    @(negedge clk_i);
    cpu_addr_i = 32'h0000_1240;
    cpu_MemWrite_i = 1'b0;
    cpu_MemRead_i = 1'b1;
    #1;
    for (k = 0; k < 10 && mem_enable_o !== 1'b1; k++) begin
      @(negedge clk_i);
      #1;
    end
    chk("pre_rst_en", 256'(mem_enable_o), 256'(1));
    chk("pre_rst_wr", 256'(mem_write_o), 256'(0));
    chk("pre_rst_addr", 256'(mem_addr_o), 256'(32'h0000_1240));
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_en", 256'(mem_enable_o), 256'(0));
    chk("mid_rst_addr", 256'(mem_addr_o), 256'(0));
    chk("mid_rst_stall", 256'(cpu_stall_o), 256'(1));
    cpu_MemRead_i = 1'b0;
    #1;
    chk("mid_rst_idle_stall", 256'(cpu_stall_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    man_ack = 1'b1;
    #1;
    chk("late_ack_we", 256'(sram_write_o), 256'(0));
    chk("late_ack_en", 256'(mem_enable_o), 256'(0));
    @(negedge clk_i);
    man_ack = 1'b0;
    @(negedge clk_i);
    #1;
    chk("post_ack_en", 256'(mem_enable_o), 256'(0));
    auto_en = 1'b1;
    do_op(32'h0000_1240, 1'b0, 32'h0);
    do_op(32'h0000_1244, 1'b1, 32'hCAFE_F00D);
    do_op(32'h0000_1244, 1'b0, 32'h0);

    @(negedge clk_i);
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
